// File: rtl/signed_acc_pkg.sv
// Shared types and helpers for the streaming signed accumulator.
// Consumed by signed_add_ovf_w and signed_accumulator_with_overflow.
package signed_acc_pkg;

    typedef enum logic {
        StAccum,
        StHold
    } acc_state_e;

    // Two's-complement add overflows when both operands share a sign the sum does not.
    function automatic logic add_overflow(input logic a_msb, input logic b_msb,
                                          input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    function automatic logic [31:0] signed_max(input int unsigned width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] signed_min(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/signed_add_ovf_w.sv
// Combinational WIDTH-bit two's-complement adder with a signed-overflow flag.
module signed_add_ovf_w
    import signed_acc_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    assign sum = a + b;
    assign ovf = add_overflow(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);

endmodule

// File: rtl/signed_accumulator_with_overflow.sv
// Packetised signed accumulator with sticky overflow and a one-result-per-packet output.
// Define SIGNED_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module signed_accumulator_with_overflow
    import signed_acc_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_overflow,
    output logic [CNT_W-1:0] out_count
);

    acc_state_e       state_q;
    logic [WIDTH-1:0] acc_q;
    logic             sticky_q;
    logic [CNT_W-1:0] count_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_overflow_q;
    logic [CNT_W-1:0] out_count_q;

    logic [WIDTH-1:0] add_sum;
    logic             step_ov;
    logic [WIDTH-1:0] new_acc;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;
    logic             end_of_pkt;

    signed_add_ovf_w #(
        .WIDTH(WIDTH)
    ) u_add (
        .a  (acc_q),
        .b  (in_data),
        .sum(add_sum),
        .ovf(step_ov)
    );

`ifdef SIGNED_ACC_SATURATE_EN
    localparam logic [WIDTH-1:0] SatMax = WIDTH'(signed_max(WIDTH));
    localparam logic [WIDTH-1:0] SatMin = WIDTH'(signed_min(WIDTH));

    // On overflow both operands share acc's sign, so it selects the clamp direction.
    always_comb begin
        new_acc = add_sum;
        if (step_ov) begin
            new_acc = acc_q[WIDTH-1] ? SatMin : SatMax;
        end
    end
`else
    always_comb begin
        new_acc = add_sum;
    end
`endif

    assign in_ready   = (state_q == StAccum);
    assign accept     = in_valid & in_ready;
    assign cnt_inc    = count_q + 1'b1;
    assign end_of_pkt = in_last | (cnt_inc == CNT_W'(MAX_LEN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StAccum;
            acc_q          <= '0;
            sticky_q       <= 1'b0;
            count_q        <= '0;
            out_valid_q    <= 1'b0;
            out_sum_q      <= '0;
            out_overflow_q <= 1'b0;
            out_count_q    <= '0;
        end else begin
            case (state_q)
                StAccum: begin
                    if (accept) begin
                        if (end_of_pkt) begin
                            out_sum_q      <= new_acc;
                            out_overflow_q <= sticky_q | step_ov;
                            out_count_q    <= cnt_inc;
                            out_valid_q    <= 1'b1;
                            acc_q          <= '0;
                            sticky_q       <= 1'b0;
                            count_q        <= '0;
                            state_q        <= StHold;
                        end else begin
                            acc_q    <= new_acc;
                            sticky_q <= sticky_q | step_ov;
                            count_q  <= cnt_inc;
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StAccum;
                    end
                end
                default: state_q <= StAccum;
            endcase
        end
    end

    assign out_valid    = out_valid_q;
    assign out_sum      = out_sum_q;
    assign out_overflow = out_overflow_q;
    assign out_count    = out_count_q;

endmodule

// File: tb/tb_signed_accumulator_with_overflow.sv
// Directed self-checking bench for signed_accumulator_with_overflow (WIDTH=4, MAX_LEN=4).
// Expected sums follow SIGNED_ACC_SATURATE_EN when it is defined.
module tb_signed_accumulator_with_overflow;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_sum;
    logic       out_overflow;
    logic [2:0] out_count;

    int n_checks = 0;
    int n_fail   = 0;

    signed_accumulator_with_overflow #(
        .WIDTH  (4),
        .MAX_LEN(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_overflow(out_overflow),
        .out_count   (out_count)
    );

    always #5 clk = ~clk;

    logic [8:0] obs;
    assign obs = {out_valid, out_sum, out_overflow, out_count};

    // Present one beat for exactly one rising edge; inputs change 1 time unit after the edge.
    task automatic beat(input logic [3:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_checks++;
        if ({in_ready, obs} !== {1'b1, 9'b0}) begin
            n_fail++;
            $display("FAIL reset: got %b expected %b", {in_ready, obs}, {1'b1, 9'b0});
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        beat(4'd3, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early_valid: got %b expected 0", out_valid);
        end
        beat(4'd2, 1'b1);
        n_checks++;
        if ({in_ready, obs} !== {1'b0, 1'b1, 4'b0101, 1'b0, 3'd2}) begin
            n_fail++;
            $display("FAIL basic: got %b expected %b", {in_ready, obs},
                     {1'b0, 1'b1, 4'b0101, 1'b0, 3'd2});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL basic_release: got %b expected 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_overflow();
        logic [3:0] exp_pos;
        logic [3:0] exp_neg;
        logic [3:0] exp_stk;
`ifdef SIGNED_ACC_SATURATE_EN
        exp_pos = 4'b0111;
        exp_neg = 4'b1000;
        exp_stk = 4'b0111;
`else
        exp_pos = 4'b1000;
        exp_neg = 4'b0111;
        exp_stk = 4'b1001;
`endif
        beat(4'd7, 1'b0);
        beat(4'd1, 1'b1);
        n_checks++;
        if (obs !== {1'b1, exp_pos, 1'b1, 3'd2}) begin
            n_fail++;
            $display("FAIL ovf_pos: got %b expected %b", obs, {1'b1, exp_pos, 1'b1, 3'd2});
        end
        drain();
        beat(4'b1000, 1'b0);
        beat(4'b1111, 1'b1);
        n_checks++;
        if (obs !== {1'b1, exp_neg, 1'b1, 3'd2}) begin
            n_fail++;
            $display("FAIL ovf_neg: got %b expected %b", obs, {1'b1, exp_neg, 1'b1, 3'd2});
        end
        drain();
        beat(4'd7, 1'b0);
        beat(4'd1, 1'b0);
        beat(4'd1, 1'b1);
        n_checks++;
        if (obs !== {1'b1, exp_stk, 1'b1, 3'd3}) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b expected %b", obs, {1'b1, exp_stk, 1'b1, 3'd3});
        end
        drain();
        // Sticky must not leak into the following packet.
        beat(4'd1, 1'b0);
        beat(4'd1, 1'b1);
        n_checks++;
        if (obs !== {1'b1, 4'b0010, 1'b0, 3'd2}) begin
            n_fail++;
            $display("FAIL ovf_cleared: got %b expected %b", obs, {1'b1, 4'b0010, 1'b0, 3'd2});
        end
        drain();
    endtask

    task automatic test_single_and_idle();
        beat(4'b1000, 1'b1);
        n_checks++;
        if (obs !== {1'b1, 4'b1000, 1'b0, 3'd1}) begin
            n_fail++;
            $display("FAIL single: got %b expected %b", obs, {1'b1, 4'b1000, 1'b0, 3'd1});
        end
        drain();
        // Non-accepted data on idle cycles must be ignored.
        beat(4'd2, 1'b0);
        in_data = 4'd5;
        in_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_valid: got %b expected 0", out_valid);
        end
        beat(4'b1111, 1'b1);
        n_checks++;
        if (obs !== {1'b1, 4'b0001, 1'b0, 3'd2}) begin
            n_fail++;
            $display("FAIL idle_gap: got %b expected %b", obs, {1'b1, 4'b0001, 1'b0, 3'd2});
        end
        drain();
    endtask

    task automatic test_backpressure();
        beat(4'd3, 1'b0);
        beat(4'd2, 1'b1);
        in_valid = 1'b1;
        in_data  = 4'd1;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({in_ready, obs} !== {1'b0, 1'b1, 4'b0101, 1'b0, 3'd2}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got %b expected %b", i, {in_ready, obs},
                         {1'b0, 1'b1, 4'b0101, 1'b0, 3'd2});
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_release: got %b expected 01", {out_valid, in_ready});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_checks++;
        if (obs !== {1'b1, 4'b0001, 1'b0, 3'd1}) begin
            n_fail++;
            $display("FAIL bp_next: got %b expected %b", obs, {1'b1, 4'b0001, 1'b0, 3'd1});
        end
        drain();
    endtask

    task automatic test_auto_terminate();
        for (int i = 0; i < 3; i++) beat(4'd1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL auto_early: got %b expected 0", out_valid);
        end
        beat(4'd1, 1'b0);
        n_checks++;
        if (obs !== {1'b1, 4'b0100, 1'b0, 3'd4}) begin
            n_fail++;
            $display("FAIL auto_term: got %b expected %b", obs, {1'b1, 4'b0100, 1'b0, 3'd4});
        end
        drain();
        // in_last on the limiting beat must close exactly one packet.
        for (int i = 0; i < 3; i++) beat(4'd1, 1'b0);
        beat(4'd2, 1'b1);
        n_checks++;
        if (obs !== {1'b1, 4'b0101, 1'b0, 3'd4}) begin
            n_fail++;
            $display("FAIL auto_last: got %b expected %b", obs, {1'b1, 4'b0101, 1'b0, 3'd4});
        end
        drain();
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL auto_once: got %b expected 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_reset_mid();
        beat(4'd1, 1'b0);
        beat(4'd1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, obs} !== {1'b1, 9'b0}) begin
            n_fail++;
            $display("FAIL rst_mid: got %b expected %b", {in_ready, obs}, {1'b1, 9'b0});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        beat(4'd2, 1'b1);
        n_checks++;
        if (obs !== {1'b1, 4'b0010, 1'b0, 3'd1}) begin
            n_fail++;
            $display("FAIL rst_after: got %b expected %b", obs, {1'b1, 4'b0010, 1'b0, 3'd1});
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, obs} !== {1'b1, 9'b0}) begin
            n_fail++;
            $display("FAIL rst_hold: got %b expected %b", {in_ready, obs}, {1'b1, 9'b0});
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_overflow();
        test_single_and_idle();
        test_backpressure();
        test_auto_terminate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/signed_accumulator_with_overflow.md
Name: signed_accumulator_with_overflow

Overview:
Streaming signed accumulator that sits directly downstream of the combinational signed adder stage. It consumes a packet of two's-complement operands over a valid/ready handshake and adds each beat to a running sum. Per-add overflow is tracked into a sticky flag. One result (sum, overflow, beat count) is emitted per packet over a second valid/ready handshake.

Parameters:
WIDTH, 4, operand and accumulator width in bits (two's complement)
MAX_LEN, 16, maximum beats per packet; the packet auto-terminates when this many beats have been accepted
CNT_W, $clog2(MAX_LEN+1), width of the beat counter (derived; do not override)

Ports:
clk  input  1  single clock; all state on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat
in_data  input  WIDTH  signed operand
in_last  input  1  final beat of packet (qualified by in_valid)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  WIDTH  final accumulated sum
out_overflow  output  1  1 if any add in the packet overflowed
out_count  output  CNT_W  beats accepted in the packet

Behaviour:
- Reset is asynchronous and active-high and applies immediately, mid-packet included; partial packets are discarded. Reset values:
  - state=ACCUM, in_ready=1, acc=0, sticky=0, count=0
  - out_valid=0, out_sum=0, out_overflow=0, out_count=0
- FSM has two states, ACCUM and HOLD. in_ready = (state==ACCUM); it is a registered-state decode with no combinational path from out_ready.
- ACCUM, on an accepted beat (in_valid & in_ready):
  - new = acc + in_data, truncated to WIDTH bits, so it wraps.
  - step_ov = (acc[MSB]==in_data[MSB]) & (new[MSB]!=acc[MSB]).
  - acc <= new; sticky <= sticky | step_ov; count <= count+1.
- End of packet occurs when the accepted beat has in_last=1 or count+1==MAX_LEN. On that beat:
  - out_sum <= new, out_overflow <= sticky|step_ov, out_count <= count+1, out_valid <= 1.
  - acc, sticky and count clear to 0; state -> HOLD.
- Latency: out_valid rises on the cycle after the last beat is accepted.
- HOLD: in_ready=0, and out_sum, out_overflow and out_count hold stable while out_valid=1 & out_ready=0. When out_ready=1, out_valid <= 0 and state -> ACCUM. in_ready returns to 1 the following cycle; there is no same-cycle bypass.
- in_valid=0 in ACCUM leaves all state unchanged. in_data and in_last are ignored when not accepted.
- A single-beat packet yields out_sum = in_data, out_overflow=0, out_count=1.
- A packet whose in_last coincides with the MAX_LEN limit terminates once, not twice.
- The first add starts from acc=0 and can never overflow.

Optional Feature:
Macro: SIGNED_ACC_SATURATE_EN
- Defined: when step_ov=1, the value written to acc (and to out_sum on a last beat) clamps instead of wrapping.
  - Clamp to +max (0111 for WIDTH=4) if both operands are non-negative; to -min (1000) if both are negative.
  - Later adds continue from the clamped value. The sticky flag still sets.
- Undefined: wrap-around as described above. The port list is identical either way.

Decomposition:
- Package signed_acc_pkg holds:
  - state enum type (ACCUM, HOLD)
  - function computing the overflow bit for given operands and sum
  - localparam functions for signed max/min of a given width
- One sub-module is natural: signed_add_ovf_w, a WIDTH-parameterised combinational signed adder with overflow output. It is instantiated once for the acc + in_data path.

Test Plan:
1. WIDTH=4; beats 3, 2(last) -> out_sum=0101, out_overflow=0, out_count=2, out_valid one cycle after the last beat.
2. Beats 7, 1(last) -> wrap: out_sum=1000, ovf=1; with SATURATE_EN: out_sum=0111, ovf=1.
3. Beats -8(1000), -1(1111)(last) -> wrap: out_sum=0111, ovf=1; with SATURATE_EN: out_sum=1000, ovf=1.
4. Beats 7, 1, 1(last) -> wrap: out_sum=1001, ovf=1 (sticky despite the final add not overflowing), count=3; with SATURATE_EN: out_sum=0111, ovf=1.
5. Backpressure test:
   - Hold out_ready=0 for 3 cycles after out_valid rises, with in_valid=1 throughout.
   - Required: in_ready=0, outputs stable, no beat consumed.
   - Then assert out_ready=1: out_valid=0 next cycle, in_ready=1, and the next packet's sum starts from 0.
6. Auto-terminate and reset:
   - MAX_LEN=4; four beats of 1 with in_last=0 -> out_sum=0100, out_count=4.
   - Separately, assert rst after 2 beats: all outputs read reset values immediately; the next packet 2(last) gives out_sum=0010, count=1.
